// File: rtl/gf180mcu_osu_sc_pkg.sv
// Shared definitions for the gp9t3v3 registered OAI cell family.
package gf180mcu_osu_sc_pkg;

    // Lane function select, sampled with each accepted beat.
    typedef enum logic {
        OAI_MODE_21  = 1'b0,
        OAI_MODE_211 = 1'b1
    } oai_mode_e;

    // Deepest pipeline supported; OCC is sized to count up to this.
    localparam int STAGES_MAX = 4;
    localparam int OCC_W      = 3;

    // Number of set bits in a stage-valid vector (unused upper bits tied low).
    function automatic logic [OCC_W-1:0] valid_count(input logic [STAGES_MAX-1:0] v);
        logic [OCC_W-1:0] n;
        n = '0;
        for (int i = 0; i < STAGES_MAX; i++) begin
            n = n + {{(OCC_W-1){1'b0}}, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/gf180mcu_osu_sc_gp9t3v3__oai_pipe_stage.sv
// One elastic pipeline slot: valid + data register with a pass-through ready chain.
module gf180mcu_osu_sc_gp9t3v3__oai_pipe_stage #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    input  logic             next_ready,
    output logic             ready,
    output logic             valid,
    output logic [WIDTH-1:0] data
);

    // An empty slot always accepts, so bubbles collapse even under a stall.
    assign ready = ~valid | next_ready;

    // Advance when ready; data only captures real beats so a drained slot keeps its last value.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid <= 1'b0;
            data  <= '0;
        end else if (ready) begin
            valid <= in_valid;
            if (in_valid) begin
                data <= in_data;
            end
        end
    end

endmodule

// File: rtl/gf180mcu_osu_sc_gp9t3v3__oai211_pipe.sv
// WIDTH-lane OAI21/OAI211 front end feeding a STAGES-deep elastic valid/ready pipeline.
module gf180mcu_osu_sc_gp9t3v3__oai211_pipe
    import gf180mcu_osu_sc_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic             CLK,
    input  logic             RN,
    input  logic             MODE,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [WIDTH-1:0] A0,
    input  logic [WIDTH-1:0] A1,
    input  logic [WIDTH-1:0] B,
    input  logic [WIDTH-1:0] C,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [WIDTH-1:0] Y,
    output logic [OCC_W-1:0] OCC
);

    // Index 0 is the input side, index STAGES the output side of the chain.
    logic [STAGES:0]            vld;
    logic [STAGES:0][WIDTH-1:0] dat;
    logic [STAGES:0]            rdy;
    logic [WIDTH-1:0]           c_eff;
    logic [WIDTH-1:0]           y_in;
    logic [STAGES_MAX-1:0]      vld_ext;

    // In OAI21 mode the C term is forced to 1 so an undriven C cannot leak X into Y.
    always_comb begin
        c_eff = (MODE == OAI_MODE_211) ? C : {WIDTH{1'b1}};
    end

    // Combinational lane function evaluated ahead of stage 0.
    for (genvar l = 0; l < WIDTH; l++) begin : g_lane
        assign y_in[l] = ~((A0[l] | A1[l]) & B[l] & c_eff[l]);
    end

    assign vld[0]      = IN_VALID;
    assign dat[0]      = y_in;
    assign rdy[STAGES] = OUT_READY;

    for (genvar s = 0; s < STAGES; s++) begin : g_stage
        gf180mcu_osu_sc_gp9t3v3__oai_pipe_stage #(
            .WIDTH(WIDTH)
        ) u_stage (
            .clk       (CLK),
            .rst_n     (RN),
            .in_valid  (vld[s]),
            .in_data   (dat[s]),
            .next_ready(rdy[s+1]),
            .ready     (rdy[s]),
            .valid     (vld[s+1]),
            .data      (dat[s+1])
        );
    end

    assign IN_READY  = rdy[0];
    assign OUT_VALID = vld[STAGES];
    assign Y         = dat[STAGES];

    // Occupancy is a pure function of the stage valids, so it moves on the same edge.
    always_comb begin
        vld_ext               = '0;
        vld_ext[STAGES-1:0]   = vld[STAGES:1];
    end

    assign OCC = valid_count(vld_ext);

    specify
        (CLK *> Y)         = 0;
        (CLK *> OUT_VALID) = 0;
        (CLK *> OCC)       = 0;
    endspecify

endmodule

// File: tb/tb_gf180mcu_osu_sc_gp9t3v3__oai211_pipe.sv
// Scoreboard bench for the pipelined OAI21/OAI211 bank (WIDTH=8, STAGES=2).
module tb_gf180mcu_osu_sc_gp9t3v3__oai211_pipe;

    localparam int WIDTH  = 8;
    localparam int STAGES = 2;

    logic             CLK = 1'b0;
    logic             RN;
    logic             MODE;
    logic             IN_VALID;
    logic             IN_READY;
    logic [WIDTH-1:0] A0, A1, B, C;
    logic             OUT_VALID;
    logic             OUT_READY;
    logic [WIDTH-1:0] Y;
    logic [2:0]       OCC;

    int checks   = 0;
    int failures = 0;
    int n_in     = 0;
    int n_out    = 0;
    logic [WIDTH-1:0] sb[$];

    gf180mcu_osu_sc_gp9t3v3__oai211_pipe #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
        .CLK(CLK), .RN(RN), .MODE(MODE), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
        .A0(A0), .A1(A1), .B(B), .C(C),
        .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .Y(Y), .OCC(OCC)
    );

    always #5 CLK = ~CLK;

    function automatic logic [WIDTH-1:0] oai_ref(input logic [WIDTH-1:0] a0, a1, b, c,
                                                 input logic mode);
        logic [WIDTH-1:0] cc;
        cc = mode ? c : {WIDTH{1'b1}};
        return ~((a0 | a1) & b & cc);
    endfunction

    // Scoreboard: push on acceptance, compare/pop on output, track occupancy.
    always @(negedge CLK) begin
        if (RN !== 1'b1) begin
            sb.delete();
        end else begin
            checks++;
            if (OCC !== 3'(sb.size())) begin
                failures++;
                $display("FAIL sb_occ: got %0d expected %0d at %0t", OCC, sb.size(), $time);
            end
            if (OUT_VALID === 1'b1) begin
                checks++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL sb_spurious: Y=%h with no beat expected at %0t", Y, $time);
                end else if (Y !== sb[0]) begin
                    failures++;
                    $display("FAIL sb_data: got %h expected %h at %0t", Y, sb[0], $time);
                end
                if (OUT_READY === 1'b1 && sb.size() != 0) begin
                    void'(sb.pop_front());
                    n_out++;
                end
            end
            if (IN_VALID === 1'b1 && IN_READY === 1'b1) begin
                sb.push_back(oai_ref(A0, A1, B, C, MODE));
                n_in++;
            end
        end
    end

    task automatic rand_inputs();
        A0   = 8'($urandom);
        A1   = 8'($urandom);
        B    = 8'($urandom);
        C    = 8'($urandom);
        MODE = 1'($urandom);
    endtask

    task automatic drain();
        int k;
        IN_VALID  = 1'b0;
        OUT_READY = 1'b1;
        k = 0;
        while (OCC !== 3'd0 && k < 50) begin
            @(posedge CLK); #1;
            k++;
        end
        checks++;
        if (OCC !== 3'd0) begin
            failures++;
            $display("FAIL drain_timeout: OCC=%0d expected 0", OCC);
        end
    endtask

    task automatic test_reset();
        RN = 1'b0; IN_VALID = 1'b1; OUT_READY = 1'b0;
        rand_inputs();
        repeat (2) @(posedge CLK);
        #1;
        checks++;
        if (OUT_VALID !== 1'b0 || OCC !== 3'd0 || Y !== 8'h00) begin
            failures++;
            $display("FAIL reset_hold: vld=%b occ=%0d y=%h expected 0/0/00", OUT_VALID, OCC, Y);
        end
        RN = 1'b1; IN_VALID = 1'b0;
        #1;
        checks++;
        if (IN_READY !== 1'b1) begin
            failures++;
            $display("FAIL reset_in_ready: got %b expected 1", IN_READY);
        end
        @(posedge CLK); #1;
        checks++;
        if (OUT_VALID !== 1'b0 || OCC !== 3'd0 || Y !== 8'h00) begin
            failures++;
            $display("FAIL reset_release: vld=%b occ=%0d y=%h expected 0/0/00", OUT_VALID, OCC, Y);
        end
    endtask

    task automatic test_truth_table();
        logic [WIDTH-1:0] exp_y [2];
        exp_y[0] = 8'hC3;
        exp_y[1] = 8'hC0;
        for (int m = 0; m < 2; m++) begin
            OUT_READY = 1'b1;
            A0 = 8'h0F; A1 = 8'h30; B = 8'hFF;
            MODE = (m == 0) ? 1'b1 : 1'b0;
            C    = (m == 0) ? 8'h3C : 8'hxx;
            IN_VALID = 1'b1;
            @(posedge CLK); #1;
            IN_VALID = 1'b0;
            checks++;
            if (OUT_VALID !== 1'b0) begin
                failures++;
                $display("FAIL tt_early_%0d: out_valid=%b expected 0 after one edge", m, OUT_VALID);
            end
            @(posedge CLK); #1;
            checks++;
            if (OUT_VALID !== 1'b1 || Y !== exp_y[m]) begin
                failures++;
                $display("FAIL tt_y_%0d: vld=%b y=%h expected 1/%h", m, OUT_VALID, Y, exp_y[m]);
            end
        end
        C = 8'h00;
        drain();
    endtask

    task automatic test_stream();
        int out0;
        out0 = n_out;
        OUT_READY = 1'b1;
        for (int i = 0; i < 16; i++) begin
            rand_inputs();
            IN_VALID = 1'b1;
            #1;
            checks++;
            if (IN_READY !== 1'b1) begin
                failures++;
                $display("FAIL stream_ready: beat %0d in_ready=%b expected 1", i, IN_READY);
            end
            @(posedge CLK); #1;
            if (i == 0) begin
                checks++;
                if (OUT_VALID !== 1'b0) begin
                    failures++;
                    $display("FAIL stream_latency: out_valid=%b expected 0 at cycle 1", OUT_VALID);
                end
            end else begin
                checks++;
                if (OUT_VALID !== 1'b1 || OCC !== 3'd2) begin
                    failures++;
                    $display("FAIL stream_steady: cycle %0d vld=%b occ=%0d expected 1/2",
                             i + 1, OUT_VALID, OCC);
                end
            end
        end
        drain();
        checks++;
        if (n_out - out0 != 16) begin
            failures++;
            $display("FAIL stream_count: got %0d outputs expected 16", n_out - out0);
        end
    endtask

    task automatic test_backpressure();
        int in0, out0;
        logic acc;
        in0 = n_in; out0 = n_out;
        acc = 1'b1;
        for (int c = 0; c < 20; c++) begin
            if (acc) rand_inputs();
            IN_VALID  = 1'b1;
            OUT_READY = (c >= 4 && c <= 8) ? 1'b0 : 1'b1;
            #1;
            if (c == 8) begin
                checks++;
                if (OCC !== 3'd2 || IN_READY !== 1'b0) begin
                    failures++;
                    $display("FAIL bp_full: occ=%0d in_ready=%b expected 2/0", OCC, IN_READY);
                end
            end
            acc = IN_READY;
            @(posedge CLK); #1;
        end
        drain();
        checks++;
        if ((n_in - in0) != (n_out - out0) || sb.size() != 0) begin
            failures++;
            $display("FAIL bp_conserve: in=%0d out=%0d pending=%0d expected equal/0",
                     n_in - in0, n_out - out0, sb.size());
        end
    endtask

    task automatic test_bubble();
        OUT_READY = 1'b0;
        rand_inputs();
        IN_VALID = 1'b1;
        @(posedge CLK); #1;
        IN_VALID = 1'b0;
        @(posedge CLK); #1;
        checks++;
        if (OUT_VALID !== 1'b1 || OCC !== 3'd1) begin
            failures++;
            $display("FAIL bubble_first: vld=%b occ=%0d expected 1/1", OUT_VALID, OCC);
        end
        rand_inputs();
        IN_VALID = 1'b1;
        #1;
        checks++;
        if (IN_READY !== 1'b1) begin
            failures++;
            $display("FAIL bubble_accept: in_ready=%b expected 1", IN_READY);
        end
        @(posedge CLK); #1;
        IN_VALID = 1'b0;
        #1;
        checks++;
        if (OCC !== 3'd2 || IN_READY !== 1'b0) begin
            failures++;
            $display("FAIL bubble_full: occ=%0d in_ready=%b expected 2/0", OCC, IN_READY);
        end
    endtask

    task automatic test_mid_reset();
        logic [WIDTH-1:0] exp;
        RN = 1'b0;
        rand_inputs();
        IN_VALID = 1'b1;
        @(posedge CLK); #1;
        checks++;
        if (OCC !== 3'd0 || OUT_VALID !== 1'b0 || Y !== 8'h00) begin
            failures++;
            $display("FAIL midrst_clear: occ=%0d vld=%b y=%h expected 0/0/00", OCC, OUT_VALID, Y);
        end
        RN = 1'b1;
        OUT_READY = 1'b1;
        A0 = 8'h81; A1 = 8'h00; B = 8'hF1; C = 8'h0F; MODE = 1'b1;
        exp = 8'hFE;
        @(posedge CLK); #1;
        IN_VALID = 1'b0;
        checks++;
        if (OUT_VALID !== 1'b0) begin
            failures++;
            $display("FAIL midrst_early: out_valid=%b expected 0", OUT_VALID);
        end
        @(posedge CLK); #1;
        checks++;
        if (OUT_VALID !== 1'b1 || Y !== exp) begin
            failures++;
            $display("FAIL midrst_beat: vld=%b y=%h expected 1/%h", OUT_VALID, Y, exp);
        end
        drain();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        RN = 1'b0; MODE = 1'b0; IN_VALID = 1'b0; OUT_READY = 1'b0;
        A0 = '0; A1 = '0; B = '0; C = '0;
        @(posedge CLK); #1;
        test_reset();
        test_truth_table();
        test_stream();
        test_backpressure();
        test_bubble();
        test_mid_reset();
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL final_pending: %0d beats outstanding expected 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
